// File: rtl/led_pulse_driver_if.sv
// Bundle of the event/indicator signals between control logic and the LED driver.
// The slave modport is the driver side; the master modport is the control side.
interface led_pulse_driver_if #(
  parameter int PEND_W = 4
);
  logic              Event;
  logic              Hold;
  logic              LedOut;
  logic              Busy;
  logic [PEND_W-1:0] Pending;
  logic              Overflow;

  modport master (
    output Event,
    output Hold,
    input  LedOut,
    input  Busy,
    input  Pending,
    input  Overflow
  );

  modport slave (
    input  Event,
    input  Hold,
    output LedOut,
    output Busy,
    output Pending,
    output Overflow
  );
endinterface

// File: rtl/led_pulse_driver.sv
// LED pulse driver: turns single-cycle event strobes into visible blinks with a
// guaranteed on-time and off-gap. Strobes arriving mid-blink queue up in a
// saturating pending counter; a sticky flag records any strobe dropped at
// saturation. Hold forces the LED on without disturbing blink timing.
module led_pulse_driver #(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int OFF_CYCLES = 5_000_000,
  parameter int CNT_W      = 23,
  parameter int PEND_W     = 4
) (
  input  logic                c50M,
  input  logic                Reset,
  led_pulse_driver_if.slave   io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  timer, timer_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic              ovf, ovf_nxt;
  logic              led, led_nxt;
  logic              busy;
  logic              consume;

  // State register plus timer, queue, overflow flag and registered LED drive.
  always_ff @(posedge c50M) begin
    if (Reset) begin
      state <= IDLE;
      timer <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
      led   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
      led   <= led_nxt;
    end
  end

  // Next-state, timer reload/decrement and pending-queue bookkeeping.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    consume   = 1'b0;
    pend_nxt  = pend;
    ovf_nxt   = ovf;

    case (state)
      IDLE: begin
        if (pend != '0) begin
          state_nxt = ON;
          timer_nxt = ON_LOAD;
          consume   = 1'b1;
        end
      end
      ON: begin
        if (timer == '0) begin
          state_nxt = GAP;
          timer_nxt = OFF_LOAD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      GAP: begin
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (pend != '0) begin
          state_nxt = ON;
          timer_nxt = ON_LOAD;
          consume   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    // A strobe and a consume on the same edge cancel; a strobe at saturation
    // with nothing consumed is dropped and flagged.
    case ({io.Event, consume})
      2'b10: begin
        if (pend == PEND_MAX) ovf_nxt  = 1'b1;
        else                  pend_nxt = pend + 1'b1;
      end
      2'b01:   pend_nxt = pend - 1'b1;
      default: pend_nxt = pend;
    endcase
  end

  // Output decode: LED follows the upcoming state (or Hold); Busy from state register.
  always_comb begin
    led_nxt = io.Hold | (state_nxt == ON);
    busy    = (state != IDLE);
  end

  assign io.LedOut   = led;
  assign io.Busy     = busy;
  assign io.Pending  = pend;
  assign io.Overflow = ovf;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver with ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
// Edge numbers count rising edges after the reset edge (reset edge = 0).
module tb_led_pulse_driver;
  localparam int PW = 2;

  logic c50M  = 1'b0;
  logic Reset = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   edge_n = 0;

  led_pulse_driver_if #(.PEND_W(PW)) bus ();

  led_pulse_driver #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .CNT_W     (3),
    .PEND_W    (PW)
  ) dut (
    .c50M (c50M),
    .Reset(Reset),
    .io   (bus)
  );

  always #5 c50M = ~c50M;

  // Apply inputs for one rising edge, then sample 1 time unit after it.
  task automatic edge_with(input logic ev, input logic hd, input logic rs);
    bus.Event = ev;
    bus.Hold  = hd;
    Reset     = rs;
    @(posedge c50M);
    #1;
    edge_n++;
    bus.Event = 1'b0;
    Reset     = 1'b0;
  endtask

  task automatic do_reset();
    edge_with(1'b0, 1'b0, 1'b1);
    edge_n = 0;
  endtask

  task automatic test_reset();
    logic ev, rs;
    do_reset();
    total++; if (bus.LedOut !== 1'b0) $display("FAIL reset_led got %b want 0", bus.LedOut); else passed++;
    total++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.Busy); else passed++;
    total++; if (bus.Pending !== 2'd0) $display("FAIL reset_pend got %0d want 0", bus.Pending); else passed++;
    total++; if (bus.Overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.Overflow); else passed++;
    // Events at 9,10,11 -> ON from edge 10 with two queued; reset (with an Event) at 12.
    for (int e = 1; e <= 22; e++) begin
      ev = ((e >= 9 && e <= 12) || e == 20);
      rs = (e == 12);
      edge_with(ev, 1'b0, rs);
      if (e == 11) begin
        total++; if (bus.Pending !== 2'd2) $display("FAIL midon_pend e=%0d got %0d want 2", e, bus.Pending); else passed++;
        total++; if (bus.LedOut !== 1'b1) $display("FAIL midon_led e=%0d got %b want 1", e, bus.LedOut); else passed++;
      end
      if (e == 12) begin
        total++; if (bus.Pending !== 2'd0) $display("FAIL abort_pend got %0d want 0", bus.Pending); else passed++;
        total++; if (bus.Busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.Busy); else passed++;
        total++; if (bus.Overflow !== 1'b0) $display("FAIL abort_ovf got %b want 0", bus.Overflow); else passed++;
      end
      if (e >= 12 && e <= 20) begin
        total++; if (bus.LedOut !== 1'b0) $display("FAIL abort_led e=%0d got %b want 0", e, bus.LedOut); else passed++;
      end
      if (e == 20) begin
        total++; if (bus.Pending !== 2'd1) $display("FAIL rearm_pend got %0d want 1", bus.Pending); else passed++;
      end
      if (e == 21 || e == 22) begin
        total++; if (bus.LedOut !== 1'b1) $display("FAIL rearm_led e=%0d got %b want 1", e, bus.LedOut); else passed++;
      end
      if (e == 21) begin
        total++; if (bus.Pending !== 2'd0) $display("FAIL rearm_pend2 got %0d want 0", bus.Pending); else passed++;
      end
    end
  endtask

  task automatic test_single();
    logic exp_led, exp_busy;
    logic [PW-1:0] exp_pend;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      edge_with(e == 10, 1'b0, 1'b0);
      exp_led  = (e >= 11 && e <= 14);
      exp_busy = (e >= 11 && e <= 17);
      exp_pend = (e == 10) ? 2'd1 : 2'd0;
      total++; if (bus.LedOut !== exp_led) $display("FAIL single_led e=%0d got %b want %b", e, bus.LedOut, exp_led); else passed++;
      total++; if (bus.Busy !== exp_busy) $display("FAIL single_busy e=%0d got %b want %b", e, bus.Busy, exp_busy); else passed++;
      total++; if (bus.Pending !== exp_pend) $display("FAIL single_pend e=%0d got %0d want %0d", e, bus.Pending, exp_pend); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic exp_led, exp_busy;
    logic [PW-1:0] exp_pend;
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      edge_with(e >= 10 && e <= 12, 1'b0, 1'b0);
      exp_led  = (e >= 11 && e <= 14) || (e >= 18 && e <= 21) || (e >= 25 && e <= 28);
      exp_busy = (e >= 11 && e <= 31);
      if (e < 10)       exp_pend = 2'd0;
      else if (e <= 11) exp_pend = 2'd1;
      else if (e <= 17) exp_pend = 2'd2;
      else if (e <= 24) exp_pend = 2'd1;
      else              exp_pend = 2'd0;
      total++; if (bus.LedOut !== exp_led) $display("FAIL b2b_led e=%0d got %b want %b", e, bus.LedOut, exp_led); else passed++;
      total++; if (bus.Busy !== exp_busy) $display("FAIL b2b_busy e=%0d got %b want %b", e, bus.Busy, exp_busy); else passed++;
      total++; if (bus.Pending !== exp_pend) $display("FAIL b2b_pend e=%0d got %0d want %0d", e, bus.Pending, exp_pend); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic exp_led, exp_ovf, prev_led;
    logic [PW-1:0] exp_pend;
    int blinks;
    do_reset();
    blinks   = 0;
    prev_led = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      edge_with(e >= 10 && e <= 14, 1'b0, 1'b0);
      exp_led = (e >= 11 && e <= 14) || (e >= 18 && e <= 21) ||
                (e >= 25 && e <= 28) || (e >= 32 && e <= 35);
      exp_ovf = (e >= 14);
      if (e < 10)       exp_pend = 2'd0;
      else if (e <= 11) exp_pend = 2'd1;
      else if (e == 12) exp_pend = 2'd2;
      else if (e <= 17) exp_pend = 2'd3;
      else if (e <= 24) exp_pend = 2'd2;
      else if (e <= 31) exp_pend = 2'd1;
      else              exp_pend = 2'd0;
      if (bus.LedOut === 1'b1 && prev_led === 1'b0) blinks++;
      prev_led = bus.LedOut;
      total++; if (bus.LedOut !== exp_led) $display("FAIL ovf_led e=%0d got %b want %b", e, bus.LedOut, exp_led); else passed++;
      total++; if (bus.Overflow !== exp_ovf) $display("FAIL ovf_flag e=%0d got %b want %b", e, bus.Overflow, exp_ovf); else passed++;
      total++; if (bus.Pending !== exp_pend) $display("FAIL ovf_pend e=%0d got %0d want %0d", e, bus.Pending, exp_pend); else passed++;
    end
    total++; if (blinks !== 4) $display("FAIL ovf_blinks got %0d want 4", blinks); else passed++;
  endtask

  task automatic test_hold();
    logic exp_led, exp_busy, hd;
    logic [PW-1:0] exp_pend;
    do_reset();
    total++; if (bus.Overflow !== 1'b0) $display("FAIL hold_ovf_cleared got %b want 0", bus.Overflow); else passed++;
    for (int e = 1; e <= 26; e++) begin
      hd = (e == 15 || e == 16);
      edge_with(e == 10 || e == 11, hd, 1'b0);
      exp_led  = (e >= 11 && e <= 16) || (e >= 18 && e <= 21);
      exp_busy = (e >= 11 && e <= 24);
      if (e >= 10 && e <= 17) exp_pend = 2'd1;
      else                    exp_pend = 2'd0;
      total++; if (bus.LedOut !== exp_led) $display("FAIL hold_led e=%0d got %b want %b", e, bus.LedOut, exp_led); else passed++;
      total++; if (bus.Busy !== exp_busy) $display("FAIL hold_busy e=%0d got %b want %b", e, bus.Busy, exp_busy); else passed++;
      total++; if (bus.Pending !== exp_pend) $display("FAIL hold_pend e=%0d got %0d want %0d", e, bus.Pending, exp_pend); else passed++;
    end
    bus.Hold = 1'b0;
  endtask

  task automatic test_gap_expiry();
    logic exp_led, exp_busy;
    logic [PW-1:0] exp_pend;
    int gap;
    do_reset();
    gap = 0;
    for (int e = 1; e <= 26; e++) begin
      edge_with(e == 10 || e == 18, 1'b0, 1'b0);
      exp_led  = (e >= 11 && e <= 14) || (e >= 19 && e <= 22);
      exp_busy = (e >= 11 && e <= 17) || (e >= 19 && e <= 25);
      exp_pend = (e == 10 || e == 18) ? 2'd1 : 2'd0;
      if (e >= 15 && e <= 19 && bus.LedOut === 1'b0) gap++;
      total++; if (bus.LedOut !== exp_led) $display("FAIL gapx_led e=%0d got %b want %b", e, bus.LedOut, exp_led); else passed++;
      total++; if (bus.Busy !== exp_busy) $display("FAIL gapx_busy e=%0d got %b want %b", e, bus.Busy, exp_busy); else passed++;
      total++; if (bus.Pending !== exp_pend) $display("FAIL gapx_pend e=%0d got %0d want %0d", e, bus.Pending, exp_pend); else passed++;
    end
    total++; if (gap !== 4) $display("FAIL gapx_len got %0d want 4", gap); else passed++;
  endtask

  initial begin
    bus.Event = 1'b0;
    bus.Hold  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_hold();
    test_gap_expiry();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
